chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock with a registered inter-chunk carry.
- Trades latency for a narrow carry chain.
- Uses valid/ready handshakes on both sides, so it drops into streaming datapaths in the learning/basic arithmetic set.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK is derived as WIDTH/CHUNK. It is a localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with CHUNKED_ADDER_OVF_EN.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, internal carry=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a, b, cin into the operand regs, set idx=0, carry=cin, go to RUN.
  - RUN: in_ready=0. Each cycle compute {c,s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry, with a CHUNK+1-bit result. Write s into sum[idx*CHUNK +: CHUNK] and set carry=c. If idx==NCHUNK-1, set cout=c, out_valid=1, go to DONE; else idx++.
  - DONE: in_ready=0, out_valid=1. sum, cout and ovf are held stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE.
- Latency and throughput:
  - Accept at edge E; out_valid rises at edge E+NCHUNK.
  - CHUNK=WIDTH gives 1-cycle latency.
  - Minimum issue interval is NCHUNK+2 cycles (result handshake cycle, then IDLE accept).
  - No overlap of operations.
- Register usage:
  - Only the registered copies of a and b are used during RUN; input changes after acceptance have no effect.
  - sum bits for chunks not yet computed retain their previous-result values until overwritten. They are only guaranteed valid when out_valid=1.
- Boundary conditions:
  - in_valid while busy is ignored; the source must hold it until in_ready.
  - out_ready asserted while not out_valid has no effect.
  - Maximum case: a=b=all-ones, cin=1 gives sum=all-ones, cout=1.
- Reset mid-operation (RUN or DONE): next edge returns to IDLE with all outputs at reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Reset has priority over all handshakes in the same cycle.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- When defined:
  - ovf port exists.
  - In the final RUN cycle, ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum MSB != a[WIDTH-1]), using the registered operands.
  - ovf is registered alongside cout, held in DONE, and cleared by reset.
- When undefined: the ovf port and its logic are absent, and the rest of the behaviour is identical.

Test Plan (WIDTH=8, CHUNK=4 unless noted):
- a=0x0F, b=0x01, cin=0 accepted at edge E -> out_valid at E+2, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Both results handshaken back-to-back with out_ready=1; second in_ready seen at E+3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid stable and in_ready=0 throughout. out_ready=1 -> IDLE next edge.
- Reset asserted one cycle into RUN -> next edge: in_ready=1, out_valid=0, sum=0; no result emitted. A fresh 0x12+0x34 then yields sum=0x46.
- CHUNK=8, WIDTH=8: a=0xAA, b=0x55, cin=1 -> out_valid one edge after accept, sum=0x00, cout=1. WIDTH=32, CHUNK=1: a=0xFFFFFFFF, b=1 -> latency 32, sum=0, cout=1.
- With CHUNKED_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0. a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1. a=0x7F, b=0x80 -> ovf=0.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output is built when CHUNKED_ADDER_OVF_EN is defined.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [BW-1:0]     base;
  logic [CHUNK:0]    chunk_res;

  // The single narrow adder: one chunk of the registered operands plus the carry.
  always_comb begin
    base      = BW'(idx_q) * BW'(CHUNK);
    chunk_res = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = cin;
          state_d = RUN;
        end
      end
      RUN: begin
        // Upper chunks keep the previous result until their turn comes.
        sum_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d              = chunk_res[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_res[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: three instances (8/4, 8/8, 32/1) driven one at a time.
// Overflow results are compared only when CHUNKED_ADDER_OVF_EN is defined.
module tb_chunked_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic        in_valid, out_ready, cin;
  logic [31:0] a_drv, b_drv;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  logic        in_ready0, out_valid0, cout0;
  logic [7:0]  sum0;
  logic        in_ready1, out_valid1, cout1;
  logic [7:0]  sum1;
  logic        in_ready2, out_valid2, cout2;
  logic [31:0] sum2;
  logic        in_ready_m, out_valid_m, cout_m;
  logic [31:0] sum_m;
`ifdef CHUNKED_ADDER_OVF_EN
  logic        ovf0, ovf1, ovf2, ovf_m;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_adder #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(in_ready0),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin), .out_valid(out_valid0),
    .out_ready(out_ready && sel == 0), .sum(sum0), .cout(cout0)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(in_ready1),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin), .out_valid(out_valid1),
    .out_ready(out_ready && sel == 1), .sum(sum1), .cout(cout1)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  chunked_adder #(.WIDTH(32), .CHUNK(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(in_ready2),
    .a(a_drv), .b(b_drv), .cin(cin), .out_valid(out_valid2),
    .out_ready(out_ready && sel == 2), .sum(sum2), .cout(cout2)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always_comb begin
    in_ready_m  = (sel == 0) ? in_ready0  : (sel == 1) ? in_ready1  : in_ready2;
    out_valid_m = (sel == 0) ? out_valid0 : (sel == 1) ? out_valid1 : out_valid2;
    cout_m      = (sel == 0) ? cout0      : (sel == 1) ? cout1      : cout2;
    sum_m       = (sel == 0) ? {24'd0, sum0} : (sel == 1) ? {24'd0, sum1} : sum2;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_m       = (sel == 0) ? ovf0       : (sel == 1) ? ovf1       : ovf2;
`endif
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, presents one operand set, records the model result and accept cycle.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic c);
    int          n = 0;
    int          w;
    logic [63:0] mask, full;
    exp_t        e;
    while (!in_ready_m && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready_m}, 64'd1);
    w      = (sel == 2) ? 32 : 8;
    mask   = (64'd1 << w) - 64'd1;
    full   = ({32'd0, av} & mask) + ({32'd0, bv} & mask) + {63'd0, c};
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (av[w-1] == bv[w-1]) && (e.sum[w-1] != av[w-1]);
    sb.push_back(e);
    a_drv    = av;
    b_drv    = bv;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    a_drv    = $urandom;
    b_drv    = $urandom;
    cin      = ~c;
  endtask

  // Waits for out_valid, checks latency and the scoreboard head, optionally completes the handshake.
  task automatic checkOutput(input string tag, input int lat, input bit handshake);
    int   n = 0;
    exp_t e;
    while (!out_valid_m && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, {63'd0, out_valid_m}, 64'd1);
    check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
    check({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, {32'd0, sum_m}, {32'd0, e.sum});
      check({tag, "_cout"}, {63'd0, cout_m}, {63'd0, e.cout});
`ifdef CHUNKED_ADDER_OVF_EN
      check({tag, "_ovf"}, {63'd0, ovf_m}, {63'd0, e.ovf});
`endif
    end
    if (handshake) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_clear"}, {63'd0, out_valid_m}, 64'd0);
      check({tag, "_ready_back"}, {63'd0, in_ready_m}, 64'd1);
      check({tag, "_ready_cycle"}, 64'(cyc - acc_cyc), 64'(lat + 1));
    end
  endtask

  initial begin
    sel       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cin       = 1'b0;
    a_drv     = '0;
    b_drv     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    check("rst_sum0", {56'd0, sum0}, 64'd0);
    check("rst_cout0", {63'd0, cout0}, 64'd0);
    check("rst_sum2", {32'd0, sum2}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_oready_valid", {63'd0, out_valid0}, 64'd0);
    check("idle_oready_ready", {63'd0, in_ready0}, 64'd1);

    applyStimulus(32'h0F, 32'h01, 1'b0);
    checkOutput("carry_chunk", 2, 1'b1);
    applyStimulus(32'hFF, 32'h01, 1'b0);
    checkOutput("wrap1", 2, 1'b1);
    applyStimulus(32'hFF, 32'h00, 1'b1);
    checkOutput("wrap2", 2, 1'b1);

    applyStimulus(32'h5A, 32'h3C, 1'b0);
    checkOutput("bp", 2, 1'b0);
    in_valid = 1'b1;
    a_drv    = 32'h11;
    b_drv    = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid0}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready0}, 64'd0);
      check("bp_sum", {56'd0, sum0}, 64'h96);
      check("bp_cout", {63'd0, cout0}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", {63'd0, out_valid0}, 64'd0);
    check("bp_release_ready", {63'd0, in_ready0}, 64'd1);

    applyStimulus(32'hAB, 32'hCD, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    check("midrst_in_ready", {63'd0, in_ready0}, 64'd1);
    check("midrst_valid", {63'd0, out_valid0}, 64'd0);
    check("midrst_sum", {56'd0, sum0}, 64'd0);
    check("midrst_cout", {63'd0, cout0}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {63'd0, out_valid0}, 64'd0);
    end
    applyStimulus(32'h12, 32'h34, 1'b0);
    checkOutput("fresh", 2, 1'b1);

    applyStimulus(32'hFF, 32'hFF, 1'b1);
    checkOutput("max", 2, 1'b1);
    applyStimulus(32'h7F, 32'h01, 1'b0);
    checkOutput("ovf_pos", 2, 1'b1);
    applyStimulus(32'h80, 32'h80, 1'b0);
    checkOutput("ovf_neg", 2, 1'b1);
    applyStimulus(32'h7F, 32'h80, 1'b0);
    checkOutput("ovf_mixed", 2, 1'b1);

    sel = 1;
    applyStimulus(32'hAA, 32'h55, 1'b1);
    checkOutput("chunk8", 1, 1'b1);

    sel = 2;
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0);
    checkOutput("chunk1", 32, 1'b1);
    applyStimulus(32'h1234_5678, 32'h8765_4321, 1'b1);
    checkOutput("chunk1_mix", 32, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
